residual_block_sequencer: RTL
=============================

Name: residual_block_sequencer

Overview:
- Downstream consumer of the macroblock's decoded CodedBlockPatternLuma/Chroma and Intra16x16 classification.
- Walks the H.264 residual() block order for one macroblock and issues one block descriptor per handshake to the CAVLC coefficient decoder.
- Each descriptor carries block type, block index and maxNumCoeff.
- Asserts done when the macroblock's residual is exhausted.

Parameters:
- CNT_W, 5, width of emitted-block counter (max 27 blocks per MB).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cbp_luma, cbp_chroma and intra16x16.
- intra16x16  in  1  MB is Intra16x16.
- cbp_luma  in  4  CodedBlockPatternLuma; bit i = 8x8 quadrant i.
- cbp_chroma  in  2  CodedBlockPatternChroma.
- blk_valid  out  1  descriptor valid.
- blk_ready  in  1  CAVLC decoder accepts the descriptor.
- blk_type  out  3  0 LUMA_DC, 1 LUMA_AC16, 2 LUMA_4x4, 3 CB_DC, 4 CR_DC, 5 CB_AC, 6 CR_AC.
- blk_idx  out  4  luma4x4BlkIdx 0..15, chroma AC 0..3, 0 for DC.
- max_num_coeff  out  5  16, 15 or 4.
- blk_skip  out  1  block not coded; only driven when the optional feature is compiled in, else tied 0.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of MB.
- blk_count  out  CNT_W  descriptors handshaked in the current MB.

Behaviour:
- Reset: blk_valid, busy, done, blk_skip = 0; blk_type, blk_idx, max_num_coeff, blk_count = 0; state IDLE.
- Reset mid-MB aborts immediately, with no done pulse.
- start is accepted only in IDLE and ignored while busy. Inputs are captured on the accepting edge. Later input changes have no effect.
- States: IDLE, LUMA_DC, LUMA, CHROMA_DC, CHROMA_AC, FINISH.
- IDLE -> LUMA_DC if intra16x16. Otherwise -> LUMA if cbp_luma != 0. Otherwise -> CHROMA_DC if cbp_chroma != 0. Otherwise -> FINISH.
- LUMA_DC: one descriptor (type 0, idx 0, max 16), then -> LUMA.
- LUMA: blk_idx steps 0..15.
  - If cbp_luma[blk_idx[3:2]] = 1, emit type 1 with max 15 when intra16x16, else type 2 with max 16.
  - If the quadrant bit = 0, jump blk_idx by 4 with no descriptor, in a single cycle per skipped quadrant.
  - After idx 15 or the last quadrant: -> CHROMA_DC if cbp_chroma != 0, else FINISH.
- CHROMA_DC: Cb DC (type 3, max 4) then Cr DC (type 4, max 4). Then -> CHROMA_AC if cbp_chroma[1], else FINISH.
- CHROMA_AC: Cb AC idx 0..3 (type 5), then Cr AC idx 0..3 (type 6), all max 15. Then -> FINISH.
- cbp_chroma = 3 is illegal and is treated as 2.
- FINISH: done = 1 for one cycle, busy drops in the same cycle, -> IDLE. A new start is accepted the cycle after done.
- Handshake:
  - Transfer occurs on a clk edge with blk_valid && blk_ready.
  - Descriptor fields are registered and held stable while blk_valid && !blk_ready.
  - The next descriptor is valid on the cycle after a transfer, so throughput is 1 block/cycle with blk_ready tied high.
- Latency: first blk_valid is the cycle after start. When there are no coded blocks, done is the cycle after start.
- blk_count increments on each transfer, clears on accepted start, and holds after done.

Optional Feature:
- RESIDUAL_SKIP_REPORT_EN defined:
  - Uncoded luma 4x4 blocks are emitted individually with blk_skip = 1 (max_num_coeff per normal rule), so the downstream decoder can zero TotalCoeff for nC prediction.
  - Uncoded chroma AC blocks are also emitted with blk_skip = 1 when cbp_chroma = 1.
  - Uncoded chroma DC is not reported when cbp_chroma = 0.
  - Skipped descriptors obey the same handshake and count in blk_count.
- Undefined: skipped quadrants are jumped silently and blk_skip is tied 0.

Test Plan:
- intra16x16 = 0, cbp_luma = 0, cbp_chroma = 0, start -> no blk_valid; done pulses the cycle after start; blk_count = 0.
- intra16x16 = 1, cbp_luma = 15, cbp_chroma = 2, blk_ready = 1 -> 27 descriptors: LUMA_DC(16), 16× LUMA_AC16 idx 0..15 (15), CB_DC, CR_DC (4), CB_AC 0..3, CR_AC 0..3 (15); done; blk_count = 27.
- intra16x16 = 0, cbp_luma = 4'b0101, cbp_chroma = 1 -> LUMA_4x4 idx 0..3 and 8..11 (max 16), CB_DC, CR_DC; blk_count = 10. With RESIDUAL_SKIP_REPORT_EN: idx 0..15 with blk_skip = 1 on 4..7 and 12..15, plus 8 chroma AC skips; blk_count = 26.
- cbp_luma = 15, blk_ready toggling 0/1 every other cycle -> fields stable while stalled; no loss or duplication; final blk_count = 16.
- start asserted again during an MB, and reset asserted at the 5th descriptor -> second start ignored; after reset blk_valid = 0, busy = 0, no done; a fresh start runs the full MB correctly.
- cbp_chroma = 3, intra16x16 = 0, cbp_luma = 0 -> identical to cbp_chroma = 2: 10 chroma descriptors.

Source files
------------

// File: rtl/residual_block_sequencer.sv
// Walks the H.264 residual() block order of one macroblock, one block descriptor per transfer.
// Build macro RESIDUAL_SKIP_REPORT_EN: also emit uncoded luma 4x4 / chroma AC blocks with blk_skip = 1.
module residual_block_sequencer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             intra16x16,
    input  logic [3:0]       cbp_luma,
    input  logic [1:0]       cbp_chroma,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [2:0]       blk_type,
    output logic [3:0]       blk_idx,
    output logic [4:0]       max_num_coeff,
    output logic             blk_skip,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] blk_count,
    output logic [2:0]       dbg_state
);

    // Handshake: a descriptor transfers on a clk edge where blk_valid && blk_ready; the fields
    // decode only from registered state, so they hold while blk_valid && !blk_ready.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LUMA_DC   = 3'd1,
        S_LUMA      = 3'd2,
        S_CHROMA_DC = 3'd3,
        S_CHROMA_AC = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_luma_exit;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nxt;
    logic             r_intra;
    logic [3:0]       r_cbpl;
    logic [1:0]       r_cbpc;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_cbpc_in;
    logic             w_coded;
    logic             w_start_acc;
    logic             w_valid;
    logic [2:0]       w_type;
    logic [3:0]       w_bidx;
    logic [4:0]       w_max;
    logic             w_busy;
    logic             w_done;
`ifdef RESIDUAL_SKIP_REPORT_EN
    logic             w_skip;
`endif

    // cbp_chroma = 3 is illegal and behaves as 2 (DC and AC coded).
    assign w_cbpc_in   = (cbp_chroma == 2'd3) ? 2'd2 : cbp_chroma;
    assign w_coded     = r_cbpl[r_idx[3:2]];
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_luma_exit = (r_cbpc != 2'd0) ? S_CHROMA_DC : S_FINISH;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid     = 1'b0;
        w_type      = 3'd0;
        w_bidx      = 4'd0;
        w_max       = 5'd0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
`ifdef RESIDUAL_SKIP_REPORT_EN
        w_skip      = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_idx_nxt = 4'd0;
                    if (intra16x16)              w_state_nxt = S_LUMA_DC;
                    else if (cbp_luma != 4'd0)   w_state_nxt = S_LUMA;
                    else if (w_cbpc_in != 2'd0)  w_state_nxt = S_CHROMA_DC;
                    else                         w_state_nxt = S_FINISH;
                end
            end
            S_LUMA_DC: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                w_max   = 5'd16;
                if (blk_ready) begin
                    w_state_nxt = S_LUMA;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_LUMA: begin
                w_busy = 1'b1;
                w_type = r_intra ? 3'd1 : 3'd2;
                w_max  = r_intra ? 5'd15 : 5'd16;
                w_bidx = r_idx;
`ifdef RESIDUAL_SKIP_REPORT_EN
                w_valid = 1'b1;
                w_skip  = !w_coded;
                if (blk_ready) begin
                    if (r_idx == 4'd15) begin
                        w_state_nxt = w_luma_exit;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
`else
                w_valid = w_coded;
                if (w_coded && blk_ready) begin
                    if (r_idx == 4'd15) begin
                        w_state_nxt = w_luma_exit;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end else if (!w_coded) begin
                    // Uncoded quadrant: one silent cycle, jump to the next quadrant.
                    if (r_idx[3:2] == 2'd3) begin
                        w_state_nxt = w_luma_exit;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = {r_idx[3:2] + 2'd1, 2'b00};
                    end
                end
`endif
            end
            S_CHROMA_DC: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                w_type  = r_idx[0] ? 3'd4 : 3'd3;
                w_max   = 5'd4;
                if (blk_ready) begin
                    if (!r_idx[0]) begin
                        w_idx_nxt = 4'd1;
                    end else begin
                        w_idx_nxt = 4'd0;
`ifdef RESIDUAL_SKIP_REPORT_EN
                        w_state_nxt = S_CHROMA_AC;
`else
                        w_state_nxt = r_cbpc[1] ? S_CHROMA_AC : S_FINISH;
`endif
                    end
                end
            end
            S_CHROMA_AC: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                w_type  = r_idx[2] ? 3'd6 : 3'd5;
                w_bidx  = {2'b00, r_idx[1:0]};
                w_max   = 5'd15;
`ifdef RESIDUAL_SKIP_REPORT_EN
                w_skip  = !r_cbpc[1];
`endif
                if (blk_ready) begin
                    if (r_idx == 4'd7) begin
                        w_state_nxt = S_FINISH;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_intra <= 1'b0;
            r_cbpl  <= 4'd0;
            r_cbpc  <= 2'd0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_start_acc) begin
                r_intra <= intra16x16;
                r_cbpl  <= cbp_luma;
                r_cbpc  <= w_cbpc_in;
                r_count <= '0;
            end else if (w_valid && blk_ready) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign blk_valid     = w_valid;
    assign blk_type      = w_type;
    assign blk_idx       = w_bidx;
    assign max_num_coeff = w_max;
    assign busy          = w_busy;
    assign done          = w_done;
    assign blk_count     = r_count;
    assign dbg_state     = r_state;
`ifdef RESIDUAL_SKIP_REPORT_EN
    assign blk_skip      = w_skip;
`else
    assign blk_skip      = 1'b0;
`endif

endmodule
